// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide sequencer.
package alu_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001,
      ALU_MD   = 4'b1111
   } alu_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] F7_MD = 7'b0000001;

endpackage

// File: rtl/mdu_iter.sv
// Bit-serial multiply/divide datapath: shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up applied combinationally on the result.
module mdu_iter
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            step,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            special,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   logic [XLEN-1:0] acc, lo, opnd;
   logic [2:0]      f3;
   logic            neg_a, neg_b, raw;

   logic            a_signed, b_signed, neg_a_in, neg_b_in, div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
      b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                 (funct3 == F3_DIV) || (funct3 == F3_REM);
      neg_a_in = a_signed & op_a[XLEN-1];
      neg_b_in = b_signed & op_b[XLEN-1];
      mag_a    = neg_a_in ? -op_a : op_a;
      mag_b    = neg_b_in ? -op_b : op_b;
      div_zero = (op_b == '0);
      div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (op_a == MIN_VAL) && (op_b == '1);
      special  = funct3[2] && (div_zero || div_ovf);
   end

   logic [XLEN:0] mul_sum, div_shift, div_diff;

   always_comb begin
      mul_sum   = {1'b0, acc} + {1'b0, (lo[0] ? opnd : '0)};
      div_shift = {acc, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
   end

   // acc holds the product high half / running remainder, lo the multiplier / quotient
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         lo    <= '0;
         opnd  <= '0;
         f3    <= '0;
         neg_a <= 1'b0;
         neg_b <= 1'b0;
         raw   <= 1'b0;
      end else if (start) begin
         f3    <= funct3;
         neg_a <= neg_a_in;
         neg_b <= neg_b_in;
         raw   <= special;
         opnd  <= funct3[2] ? mag_b : mag_a;
         if (special && div_zero) begin
            acc <= op_a;
            lo  <= '1;
         end else if (special) begin
            acc <= '0;
            lo  <= MIN_VAL;
         end else begin
            acc <= '0;
            lo  <= funct3[2] ? mag_a : mag_b;
         end
      end else if (step) begin
         if (f3[2]) begin
            if (!div_diff[XLEN]) begin
               acc <= div_diff[XLEN-1:0];
               lo  <= {lo[XLEN-2:0], 1'b1};
            end else begin
               acc <= div_shift[XLEN-1:0];
               lo  <= {lo[XLEN-2:0], 1'b0};
            end
         end else begin
            acc <= mul_sum[XLEN:1];
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
         end
      end
   end

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;

   always_comb begin
      prod_fix = (neg_a ^ neg_b) ? -{acc, lo} : {acc, lo};
      quo_fix  = (!raw && (neg_a ^ neg_b)) ? -lo : lo;
      rem_fix  = (!raw && neg_a) ? -acc : acc;
      case (f3)
         F3_MUL:                      result = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             result = quo_fix;
         default:                     result = rem_fix;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder plus sequencer for the bit-serial M-extension unit.
//   state | meaning
//   IDLE  | waiting; accepts a valid M op (stalls while one is presented)
//   MUL   | XLEN shift-add iterations
//   DIV   | XLEN restoring-divide iterations
//   DONE  | result presented with md_valid for one cycle
module alu_ctrl_mdu
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit MDU_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      aluop,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic            in_valid,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic [3:0]      out_to_alu,
   output logic            stall,
   output logic            md_valid,
   output logic [XLEN-1:0] md_result
);

   localparam int            CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] TC = CW'(XLEN - 1);

   alu_code_e code;
   logic      is_r, is_m;

   always_comb begin
      code = ALU_ADD;
      is_r = (aluop == 2'b10);
      is_m = is_r && (funct7 == F7_MD);
      case (aluop)
         2'b00: code = ALU_ADD;
         2'b01: code = ALU_SUB;
         default: begin
            if (is_m) begin
               code = MDU_EN ? ALU_MD : ALU_ADD;
            end else begin
               case (funct3)
                  3'b000:  code = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
                  3'b001:  code = ALU_SLL;
                  3'b010:  code = ALU_SLT;
                  3'b011:  code = ALU_SLTU;
                  3'b100:  code = ALU_XOR;
                  3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
                  3'b110:  code = ALU_OR;
                  default: code = ALU_AND;
               endcase
            end
         end
      endcase
   end

   assign out_to_alu = code;

   md_state_e       state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            m_req, start, step, special;
   logic [XLEN-1:0] iter_result;

   assign m_req = in_valid && (code == ALU_MD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      step      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (m_req && !flush) begin
               start     = 1'b1;
               state_nxt = special ? ST_DONE : (funct3[2] ? ST_DIV : ST_MUL);
            end
         end
         ST_MUL, ST_DIV: begin
            step = 1'b1;
            if (cnt == TC) state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // flush overrides everything, including a freshly presented M op
      if (flush) begin
         state_nxt = ST_IDLE;
         step      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      cnt <= '0;
      else if (start) cnt <= '0;
      else if (step)  cnt <= cnt + 1'b1;
   end

   generate
      if (MDU_EN) begin : g_mdu
         mdu_iter #(.XLEN(XLEN)) u_iter (
            .clk     (clk),
            .reset   (reset),
            .start   (start),
            .step    (step),
            .funct3  (funct3),
            .op_a    (op_a),
            .op_b    (op_b),
            .special (special),
            .result  (iter_result)
         );
      end else begin : g_no_mdu
         assign special     = 1'b0;
         assign iter_result = '0;
      end
   endgenerate

   assign stall     = ((state == ST_IDLE) && m_req) || (state == ST_MUL) || (state == ST_DIV);
   assign md_valid  = (state == ST_DONE);
   assign md_result = md_valid ? iter_result : '0;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: decode sweep, directed and random M ops against an arithmetic model,
// flush, mid-op reset and back-to-back acceptance.
module tb_alu_ctrl_mdu;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      aluop = '0;
   logic [6:0]      funct7 = '0;
   logic [2:0]      funct3 = '0;
   logic            in_valid = 1'b0;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            flush = 1'b0;
   logic [3:0]      out_to_alu;
   logic            stall;
   logic            md_valid;
   logic [XLEN-1:0] md_result;

   int n_chk  = 0;
   int n_fail = 0;

   alu_ctrl_mdu #(.XLEN(XLEN), .MDU_EN(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .aluop      (aluop),
      .funct7     (funct7),
      .funct3     (funct3),
      .in_valid   (in_valid),
      .op_a       (op_a),
      .op_b       (op_b),
      .flush      (flush),
      .out_to_alu (out_to_alu),
      .stall      (stall),
      .md_valid   (md_valid),
      .md_result  (md_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_code(input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3);
      logic [3:0] base [8];
      base[0] = 4'b0010; base[1] = 4'b0100; base[2] = 4'b1000; base[3] = 4'b1001;
      base[4] = 4'b0011; base[5] = 4'b0101; base[6] = 4'b0001; base[7] = 4'b0000;
      if (a == 2'b00) return 4'b0010;
      if (a == 2'b01) return 4'b0110;
      if (a == 2'b10 && f7 == 7'b0000001) return 4'b1111;
      if (f3 == 3'd0 && a == 2'b10 && f7[5]) return 4'b0110;
      if (f3 == 3'd5 && f7[5]) return 4'b0111;
      return base[f3];
   endfunction

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint     sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f3)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic bit is_bypass(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle.
   task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      int          lat, stall_cnt, exp_lat;
      bit          seen;
      logic [31:0] exp;
      exp     = ref_md(f3, a, b);
      exp_lat = is_bypass(f3, a, b) ? 1 : XLEN + 1;
      aluop = 2'b10; funct7 = 7'b0000001; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
      #1 chk({tag, "_stall_req"}, 64'(stall), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      stall_cnt = 1; lat = 0; seen = 1'b0;
      for (int i = 0; i < XLEN + 8; i++) begin
         @(negedge clk);
         lat++;
         if (md_valid) begin
            seen = 1'b1;
            break;
         end
         if (stall) stall_cnt++;
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({tag, "_result"}, 64'(md_result), 64'(exp));
         chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
         chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
         chk({tag, "_stall_in_done"}, 64'(stall), 64'd0);
         @(negedge clk);
         chk({tag, "_valid_pulse"}, 64'(md_valid), 64'd0);
      end
   endtask

   initial begin
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      int          sel, cnt, nvalid;
      bit          seen;

      repeat (2) @(negedge clk);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_valid", 64'(md_valid), 64'd0);
      chk("rst_result", 64'(md_result), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int a = 0; a < 4; a++)
         for (int f7 = 0; f7 < 128; f7++)
            for (int f3 = 0; f3 < 8; f3++) begin
               aluop = 2'(a); funct7 = 7'(f7); funct3 = 3'(f3);
               #1 chk("decode", 64'(out_to_alu), 64'(ref_code(aluop, funct7, funct3)));
            end
      aluop = 2'b10; funct7 = 7'b0100000; funct3 = 3'b101;
      #1 chk("decode_sra", 64'(out_to_alu), 64'h7);
      @(negedge clk);

      run_mop("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
      run_mop("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_mop("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
      run_mop("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
      run_mop("divu_by0", 3'd5, 32'd100, 32'd0);
      run_mop("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run_mop("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_mop("mulhsu", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

      for (int k = 0; k < 30; k++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'd0;
         if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         if (sel == 2) begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
         if (sel == 3) rb = -32'($urandom_range(1, 9));
         run_mop("rand", rf3, ra, rb);
      end

      // flush part-way through a divide
      aluop = 2'b10; funct7 = 7'b0000001; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_stall", 64'(stall), 64'd0);
      chk("flush_valid", 64'(md_valid), 64'd0);
      nvalid = 0;
      for (int i = 0; i < XLEN + 4; i++) begin
         @(negedge clk);
         if (md_valid) nvalid++;
      end
      chk("flush_no_valid", 64'(nvalid), 64'd0);
      run_mop("mul_after_flush", 3'd0, 32'd12345, 32'd678);

      // reset in the middle of a multiply
      aluop = 2'b10; funct7 = 7'b0000001; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 chk("mid_mul_stall", 64'(stall), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_stall", 64'(stall), 64'd0);
      chk("rst_mid_valid", 64'(md_valid), 64'd0);
      chk("rst_mid_result", 64'(md_result), 64'd0);
      aluop = 2'b00;
      #1 chk("rst_add_decode", 64'(out_to_alu), 64'h2);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", 64'(stall), 64'd0);
      chk("post_rst_valid", 64'(md_valid), 64'd0);
      run_mop("after_reset", 3'd1, 32'h8000_0000, 32'h8000_0000);

      // back-to-back with in_valid held; operands switch during the first op
      aluop = 2'b10; funct7 = 7'b0000001; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; in_valid = 1'b1;
      @(posedge clk); #1;
      funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7;
      seen = 1'b0;
      for (int i = 0; i < XLEN + 8; i++) begin
         @(negedge clk);
         if (md_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("b2b_first_seen", 64'(seen), 64'd1);
      chk("b2b_first_result", 64'(md_result), 64'hFFFF_FFEB);
      @(negedge clk);
      chk("b2b_idle_stall", 64'(stall), 64'd1);
      chk("b2b_idle_valid", 64'(md_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < XLEN + 8; i++) begin
         @(negedge clk);
         cnt++;
         if (md_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("b2b_second_seen", 64'(seen), 64'd1);
      chk("b2b_second_latency", 64'(cnt), 64'(XLEN + 1));
      chk("b2b_second_result", 64'(md_result), 64'd14);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter MDU_EN, default 1; when 0, M-extension decode and sequencer are absent and M ops decode as ADD.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port aluop  input  2  main-decoder class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-006 SHALL have ports funct7  input  7 and funct3  input  3, instruction fields.
REQ-007 SHALL have port in_valid  input  1  instruction in execute is valid.
REQ-008 SHALL have ports op_a, op_b  input  XLEN  rs1/rs2 operands.
REQ-009 SHALL have port flush  input  1  kill in-flight M op.
REQ-010 SHALL have port out_to_alu  output  4  ALU control code.
REQ-011 SHALL have port stall  output  1  hold pipeline.
REQ-012 SHALL have ports md_valid  output  1 and md_result  output  XLEN  M-op completion and result.

Function
REQ-013 SHALL decode out_to_alu combinationally: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MD 1111.
REQ-014 SHALL map aluop 00 -> ADD, 01 -> SUB, independent of funct fields.
REQ-015 SHALL map aluop 10 by funct3: 000 ADD/SUB (funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (funct7[5]), 110 OR, 111 AND; funct7=0000001 -> MD.
REQ-016 SHALL map aluop 11 as aluop 10 except funct3=000 is always ADD and funct7 is never MD.
REQ-017 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-018 SHALL leave IDLE only when in_valid=1, out_to_alu=MD and flush=0: funct3[2]=0 -> MUL, funct3[2]=1 -> DIV.
REQ-019 SHALL compute MUL/MULH/MULHSU/MULHU (funct3 000..011) by shift-add, one bit per cycle, XLEN cycles in MUL, then DONE.
REQ-020 SHALL compute DIV/DIVU/REM/REMU (funct3 100..111) by restoring division, one bit per cycle, XLEN cycles in DIV, then DONE; signed ops on magnitudes with sign fix-up in DONE.
REQ-021 SHALL bypass iteration on divide-by-zero (quotient all-ones, remainder op_a) and signed overflow (op_a=min, op_b=-1: quotient min, remainder 0), going IDLE -> DONE directly.
REQ-022 SHALL assert md_valid for exactly one cycle in DONE, then return to IDLE; md_result stable while md_valid=1.
REQ-023 SHALL drive stall=1 combinationally when (state=IDLE and an M op is presented) or state in {MUL, DIV}; stall=0 in DONE and for non-M ops.
REQ-024 SHALL yield total latency XLEN+1 cycles from accepting edge to md_valid (1 cycle for bypass cases).
REQ-025 SHALL capture op_a, op_b, funct3 at the accepting edge; input changes during MUL/DIV are ignored.
REQ-026 SHALL return to IDLE on the next edge when flush=1 in any state, with no md_valid; flush wins over a simultaneous new M op.
REQ-027 SHALL use an iteration counter of clog2(XLEN)+1 bits; terminal count XLEN-1 triggers DONE.

Reset
REQ-028 SHALL on reset asynchronously force state IDLE, counter 0, md_valid 0, md_result 0, stall 0; reset mid-operation discards the op.
REQ-029 SHALL keep out_to_alu purely combinational, unaffected by reset.

Structure
REQ-030 SHALL place ALU code constants, FSM state enum and M funct3 encodings in shared package alu_ctrl_pkg.
REQ-031 SHALL isolate the shift-add/restoring-divide datapath in sub-module mdu_iter (parameter XLEN), FSM and decode in alu_ctrl_mdu.

Verification
REQ-032 Decode sweep: all aluop/funct7/funct3 combos -> codes per REQ-013..016 (e.g. 10/0100000/101 -> 0111).
REQ-033 MUL 7*-3, XLEN=32 -> stall high 33 cycles, md_valid once, md_result 0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF after 1 cycle; REM 0x80000000/-1 -> 0.
REQ-035 Flush at iteration 10 of DIV -> IDLE next cycle, no md_valid, stall 0; next MUL completes correctly.
REQ-036 Reset asserted mid-MUL -> outputs zero immediately; after release ADD decodes 0010, stall 0.
REQ-037 Back-to-back M ops with in_valid held -> second accepted the cycle after DONE; operand changes during iteration ignored.
